// File: rtl/tx_flow_shaper.sv
// tx_flow_shaper: frame-atomic deficit token-bucket rate limiter on the tx
// port-management stream. Credit refills by (port rate base >> fraction select)
// bytes on each internal tick. A frame starts only while credit > 0 and always
// completes, so credit may dip negative mid-frame.
// Optional feature macro: TX_SHAPER_STATS_EN enables the o_send_byte and
// o_stall_cycle counters; without it both read 0 and their registers are removed.
module tx_flow_shaper #(
  parameter int REG_DATA_WIDTH      = 32,
  parameter int PORT_MNG_DATA_WIDTH = 128,
  parameter int TICK_CYCLES         = 800,
  parameter int CREDIT_MAX          = 16384,
  parameter int CREDIT_WIDTH        = 20
) (
  input  logic                               i_sys_clk,
  input  logic                               i_sys_rst,
  input  logic [REG_DATA_WIDTH-1:0]          i_port_rate,
  input  logic [REG_DATA_WIDTH-1:0]          i_flow_ctrl_select,
  input  logic                               i_cnt_clr,
  input  logic [PORT_MNG_DATA_WIDTH-1:0]     i_flow_data,
  input  logic [PORT_MNG_DATA_WIDTH/8-1:0]   i_flow_data_keep,
  input  logic                               i_flow_valid,
  output logic                               o_flow_ready,
  input  logic                               i_flow_last,
  output logic [PORT_MNG_DATA_WIDTH-1:0]     o_flow_data,
  output logic [PORT_MNG_DATA_WIDTH/8-1:0]   o_flow_data_keep,
  output logic                               o_flow_valid,
  input  logic                               i_flow_ready,
  output logic                               o_flow_last,
  output logic [31:0]                        o_send_package,
  output logic [31:0]                        o_send_byte,
  output logic [31:0]                        o_stall_cycle,
  output logic signed [CREDIT_WIDTH-1:0]     o_credit
);

  localparam int KEEP_W = PORT_MNG_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(KEEP_W + 1);
  localparam int TICK_W = $clog2(TICK_CYCLES);
  // Two guard bits cover credit + refill - beat without overflow.
  localparam int SUM_W  = CREDIT_WIDTH + 2;
  localparam logic signed [SUM_W-1:0] CREDIT_MAX_S = SUM_W'(CREDIT_MAX);
  localparam logic signed [SUM_W-1:0] CREDIT_MIN_S = {3'b111, {(CREDIT_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

  state_t                          state_r, state_next_s;
  logic [TICK_W-1:0]               tick_cnt_r;
  logic                            tick_s;
  logic signed [CREDIT_WIDTH-1:0]  credit_r, credit_next_s;
  logic [13:0]                     base_s, refill_s;
  logic [CNT_W-1:0]                beat_bytes_s;
  logic signed [SUM_W-1:0]         credit_ext_s, refill_ext_s, beat_ext_s, sum_s;
  logic                            credit_pos_s;
  logic                            hs_s;
  logic                            stall_inc_s;
  logic [31:0]                     send_pkg_r;

  function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  assign tick_s       = (tick_cnt_r == TICK_W'(TICK_CYCLES - 1));
  assign credit_pos_s = ~credit_r[CREDIT_WIDTH-1] && (credit_r != '0);
  assign o_credit     = credit_r;
  assign o_send_package = send_pkg_r;

  // Free-running refill tick counter, wraps at TICK_CYCLES-1.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  // Refill amount and signed credit arithmetic with ceiling/floor saturation.
  always_comb begin
    base_s = 14'd0;
    case (i_port_rate[1:0])
      2'b00:   base_s = 14'd100;
      2'b01:   base_s = 14'd1000;
      2'b10:   base_s = 14'd2500;
      2'b11:   base_s = 14'd10000;
      default: base_s = 14'd0;
    endcase
    if (tick_s) begin
      refill_s = base_s >> i_flow_ctrl_select[1:0];
    end else begin
      refill_s = 14'd0;
    end
    if (hs_s) begin
      beat_bytes_s = popcount(i_flow_data_keep);
    end else begin
      beat_bytes_s = '0;
    end
    credit_ext_s = SUM_W'(credit_r);
    refill_ext_s = $signed({{(SUM_W-14){1'b0}}, refill_s});
    beat_ext_s   = $signed({{(SUM_W-CNT_W){1'b0}}, beat_bytes_s});
    sum_s        = credit_ext_s + refill_ext_s - beat_ext_s;
    if (sum_s > CREDIT_MAX_S) begin
      credit_next_s = CREDIT_MAX_S[CREDIT_WIDTH-1:0];
    end else if (sum_s < CREDIT_MIN_S) begin
      credit_next_s = CREDIT_MIN_S[CREDIT_WIDTH-1:0];
    end else begin
      credit_next_s = sum_s[CREDIT_WIDTH-1:0];
    end
  end

  // Credit register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      credit_r <= '0;
    end else begin
      credit_r <= credit_next_s;
    end
  end

  // FSM state register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state and stream outputs; XFER is a zero-latency pass-through.
  always_comb begin
    state_next_s     = state_r;
    o_flow_valid     = 1'b0;
    o_flow_ready     = 1'b0;
    o_flow_data      = '0;
    o_flow_data_keep = '0;
    o_flow_last      = 1'b0;
    hs_s             = 1'b0;
    stall_inc_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_flow_valid && credit_pos_s) begin
          state_next_s = ST_XFER;
        end else if (i_flow_valid) begin
          stall_inc_s = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        o_flow_data      = i_flow_data;
        o_flow_data_keep = i_flow_data_keep;
        o_flow_last      = i_flow_last;
        o_flow_valid     = i_flow_valid;
        o_flow_ready     = i_flow_ready;
        hs_s             = i_flow_valid && i_flow_ready;
        if (hs_s && i_flow_last) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_XFER;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Frame counter; clear wins over a same-cycle increment.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      send_pkg_r <= 32'd0;
    end else if (i_cnt_clr) begin
      send_pkg_r <= 32'd0;
    end else if (hs_s && i_flow_last) begin
      send_pkg_r <= send_pkg_r + 32'd1;
    end else begin
      send_pkg_r <= send_pkg_r;
    end
  end

`ifdef TX_SHAPER_STATS_EN
  logic [31:0] send_byte_r, stall_r;
  logic        unused_s;
  assign unused_s = ^{i_port_rate[REG_DATA_WIDTH-1:2], i_flow_ctrl_select[REG_DATA_WIDTH-1:2]};
  assign o_send_byte   = send_byte_r;
  assign o_stall_cycle = stall_r;

  // Byte and credit-stall statistics; clear wins over increments.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      send_byte_r <= 32'd0;
      stall_r     <= 32'd0;
    end else if (i_cnt_clr) begin
      send_byte_r <= 32'd0;
      stall_r     <= 32'd0;
    end else begin
      send_byte_r <= send_byte_r + 32'(beat_bytes_s);
      stall_r     <= stall_r + 32'(stall_inc_s);
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{i_port_rate[REG_DATA_WIDTH-1:2], i_flow_ctrl_select[REG_DATA_WIDTH-1:2],
                      stall_inc_s};
  assign o_send_byte   = 32'd0;
  assign o_stall_cycle = 32'd0;
`endif

endmodule

// File: tb/tb_tx_flow_shaper.sv
// Directed bench for tx_flow_shaper: refill table plus multi-cycle sequences.
module tb_tx_flow_shaper;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [31:0]        i_port_rate = 32'd0, i_flow_ctrl_select = 32'd0;
  logic               i_cnt_clr = 1'b0;
  logic [127:0]       i_flow_data = '0;
  logic [15:0]        i_flow_data_keep = '0;
  logic               i_flow_valid = 1'b0, i_flow_last = 1'b0, i_flow_ready = 1'b1;
  logic               o_flow_ready, o_flow_valid, o_flow_last;
  logic [127:0]       o_flow_data;
  logic [15:0]        o_flow_data_keep;
  logic [31:0]        o_send_package, o_send_byte, o_stall_cycle;
  logic signed [19:0] o_credit;

  tx_flow_shaper dut (
    .i_sys_clk(clk), .i_sys_rst(rst_n), .i_port_rate(i_port_rate),
    .i_flow_ctrl_select(i_flow_ctrl_select), .i_cnt_clr(i_cnt_clr),
    .i_flow_data(i_flow_data), .i_flow_data_keep(i_flow_data_keep),
    .i_flow_valid(i_flow_valid), .o_flow_ready(o_flow_ready), .i_flow_last(i_flow_last),
    .o_flow_data(o_flow_data), .o_flow_data_keep(o_flow_data_keep),
    .o_flow_valid(o_flow_valid), .i_flow_ready(i_flow_ready), .o_flow_last(o_flow_last),
    .o_send_package(o_send_package), .o_send_byte(o_send_byte),
    .o_stall_cycle(o_stall_cycle), .o_credit(o_credit)
  );

  always #5 clk = ~clk;

`ifdef TX_SHAPER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int n_tests = 0, n_fail = 0;
  int cyc_n, beat_idx, frames_done, frames_target, n_beats;
  logic [15:0] last_keep;
  logic ds_ready, hs, stats_nz;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Upstream source: frames of n_beats, beat data = {frame number, beat index}.
  task automatic drive();
    i_flow_valid     = (frames_done < frames_target);
    i_flow_data      = {96'(frames_done), 32'(beat_idx)};
    i_flow_last      = (beat_idx == n_beats - 1);
    i_flow_data_keep = (beat_idx == n_beats - 1) ? last_keep : 16'hFFFF;
    i_flow_ready     = ds_ready;
  endtask

  task automatic redrive();
    drive();
    #1;
    hs = i_flow_valid && o_flow_ready;
  endtask

  // One clock: advance source on the handshake of the cycle just ended.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (hs) begin
      if (beat_idx == n_beats - 1) begin
        beat_idx = 0;
        frames_done++;
      end else begin
        beat_idx++;
      end
    end
    cyc_n++;
    redrive();
    if (!STATS && (o_send_byte != 32'd0 || o_stall_cycle != 32'd0)) stats_nz = 1'b1;
  endtask

  task automatic do_reset(input int rate, input int sel, input int nb, input logic [15:0] lk,
                          input int target);
    rst_n = 1'b0;
    i_port_rate = 32'(rate);
    i_flow_ctrl_select = 32'(sel);
    n_beats = nb; last_keep = lk; frames_target = target;
    frames_done = 0; beat_idx = 0; cyc_n = 0; ds_ready = 1'b1; i_cnt_clr = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    redrive();
  endtask

  typedef struct {
    int rate;
    int sel;
    int exp_credit;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int c0, s0, guard, exp_pk;
    stats_nz = 1'b0;
    hs = 1'b0;
    vecs[0] = '{0, 0, 100};
    vecs[1] = '{0, 3, 12};
    vecs[2] = '{1, 1, 500};
    vecs[3] = '{2, 0, 2500};
    vecs[4] = '{2, 3, 312};
    vecs[5] = '{3, 2, 2500};
    vecs[6] = '{3, 3, 1250};

    // Reset state (checked while reset is held).
    rst_n = 1'b0;
    n_beats = 4; last_keep = 16'hFFFF; frames_target = 1; frames_done = 0; beat_idx = 0;
    ds_ready = 1'b1; cyc_n = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_flow_valid, 0);
    chk("rst_ready", o_flow_ready, 0);
    chk("rst_last", o_flow_last, 0);
    chk("rst_data", o_flow_data[63:0], 0);
    chk("rst_keep", o_flow_data_keep, 0);
    chk("rst_credit", o_credit, 0);
    chk("rst_pkg", o_send_package, 0);

    // Refill table: credit after the first tick with no traffic.
    for (int v = 0; v < 7; v++) begin
      do_reset(vecs[v].rate, vecs[v].sel, 4, 16'hFFFF, 0);
      while (cyc_n < 799) cyc();
      chk("pre_tick_credit", o_credit, 0);
      cyc();
      chk($sformatf("refill_r%0d_s%0d", vecs[v].rate, vecs[v].sel), o_credit, vecs[v].exp_credit);
    end

    // One 64-byte frame presented at cycle 0, rate 1000M.
    do_reset(1, 0, 4, 16'hFFFF, 1);
    guard = 0;
    while (!o_flow_valid && guard < 2000) begin cyc(); guard++; end
    chk("first_valid_cycle", cyc_n, 801);
    chk("credit_at_start", o_credit, 1000);
    guard = 0;
    while (frames_done < 1 && guard < 100) begin cyc(); guard++; end
    chk("f64_credit", o_credit, 936);
    chk("f64_pkg", o_send_package, 1);
    chk("f64_stall", o_stall_cycle, STATS ? 800 : 0);
    chk("f64_bytes", o_send_byte, STATS ? 64 : 0);

    // Back-to-back 1500-byte frames.
    do_reset(1, 0, 94, 16'h0FFF, 2);
    guard = 0;
    while (frames_done < 1 && guard < 2000) begin cyc(); guard++; end
    chk("b2b_credit_1", o_credit, -500);
    guard = 0;
    while (!o_flow_valid && guard < 2000) begin cyc(); guard++; end
    chk("b2b_start2_cycle", cyc_n, 1601);
    chk("b2b_start2_credit", o_credit, 500);
    guard = 0;
    while (frames_done < 2 && guard < 2000) begin cyc(); guard++; end
    chk("b2b_credit_2", o_credit, -1000);
    chk("b2b_pkg", o_send_package, 2);
    chk("b2b_bytes", o_send_byte, STATS ? 3000 : 0);

    // Long-run throughput, 100M at 100% for 24 ticks, then 25% for 16 ticks.
    do_reset(0, 0, 4, 16'hFFFF, 1000000);
    while (cyc_n < 19200) cyc();
    exp_pk = (23 * 100 + 63) / 64;
    chk_range("rate_sel0_pkg", o_send_package, exp_pk - 1, exp_pk + 1);
    chk("rate_sel0_pkg_vs_src", o_send_package, frames_done);
    do_reset(0, 2, 4, 16'hFFFF, 1000000);
    while (cyc_n < 12800) cyc();
    exp_pk = (15 * 25 + 63) / 64;
    chk_range("rate_sel2_pkg", o_send_package, exp_pk - 1, exp_pk + 1);

    // 10G: tick coinciding with a beat gives +9984 uncapped.
    do_reset(3, 0, 1000000, 16'hFFFF, 1);
    while (cyc_n < 1599) cyc();
    chk("tick_beat_valid", o_flow_valid, 1);
    chk("tick_beat_pre", o_credit, -2768);
    cyc();
    chk("tick_beat_post", o_credit, 7216);

    // 10G idle 20 ticks: ceiling, then capped tick with a beat.
    do_reset(3, 0, 100, 16'hFFFF, 0);
    while (cyc_n < 15997) cyc();
    chk("sat_credit", o_credit, 16384);
    frames_target = 1;
    redrive();
    cyc();
    chk("sat_xfer", o_flow_valid, 1);
    cyc();
    chk("sat_beat", o_credit, 16368);
    cyc();
    chk("sat_tick_beat_capped", o_credit, 16384);
    repeat (4) cyc();
    chk("sat_drain", o_credit, 16320);

    // Downstream backpressure for 50 cycles mid-frame, then async reset mid-frame.
    do_reset(1, 0, 8, 16'hFFFF, 1);
    guard = 0;
    while (beat_idx != 3 && guard < 2000) begin cyc(); guard++; end
    ds_ready = 1'b0;
    redrive();
    c0 = o_credit;
    s0 = o_stall_cycle;
    repeat (50) cyc();
    chk("bp_credit", o_credit, 952);
    chk("bp_credit_same", o_credit, c0);
    chk("bp_stall_same", o_stall_cycle, s0);
    chk("bp_valid", o_flow_valid, 1);
    chk("bp_ready", o_flow_ready, 0);
    chk("bp_data", o_flow_data[63:0], 64'd3);
    ds_ready = 1'b1;
    redrive();
    guard = 0;
    while (frames_done < 1 && guard < 100) begin cyc(); guard++; end
    chk("bp_credit_end", o_credit, 872);
    chk("bp_bytes", o_send_byte, STATS ? 128 : 0);
    chk("bp_pkg", o_send_package, 1);
    frames_target = 2;
    redrive();
    guard = 0;
    while (beat_idx != 2 && guard < 100) begin cyc(); guard++; end
    chk("arst_pre_valid", o_flow_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", o_flow_valid, 0);
    chk("arst_ready", o_flow_ready, 0);
    chk("arst_credit", o_credit, 0);

    // Counter clear on the same cycle as the last-beat handshake.
    do_reset(1, 0, 4, 16'hFFFF, 1);
    guard = 0;
    while (!(hs && i_flow_last) && guard < 2000) begin cyc(); guard++; end
    i_cnt_clr = 1'b1;
    cyc();
    i_cnt_clr = 1'b0;
    chk("clr_src_done", frames_done, 1);
    chk("clr_pkg", o_send_package, 0);
    chk("clr_bytes", o_send_byte, 0);
    chk("clr_stall", o_stall_cycle, 0);
    chk("clr_credit", o_credit, 936);

`ifndef TX_SHAPER_STATS_EN
    chk("stats_tied_zero", stats_nz, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_flow_shaper.md
Name: tx_flow_shaper

Overview:
- Egress-side counterpart of the rx port flow-control path: a frame-atomic deficit token-bucket rate limiter on the tx port-management stream.
- Sits between the tx port scheduler (upstream) and the tx MAC (downstream) and throttles frames to the configured port rate times the selected fraction.
- Runs on a single clock with an internal refill tick; no pps pulse or CDC.
- Exposes 32-bit statistics counters in the same style as the rx side.

Parameters:
- REG_DATA_WIDTH, 32: width of the register-interface inputs.
- PORT_MNG_DATA_WIDTH, 128: stream data width; keep width is PORT_MNG_DATA_WIDTH/8.
- TICK_CYCLES, 800: clock cycles per credit refill tick (8 us at 100 MHz).
- CREDIT_MAX, 16384: bucket ceiling in bytes.
- CREDIT_WIDTH, 20: signed credit register width.

Ports:
- i_sys_clk  in  1  system clock.
- i_sys_rst  in  1  reset, asynchronous, active-low.
- i_port_rate  in  REG_DATA_WIDTH  [1:0] selects the rate: 00 = 100M, 01 = 1000M, 10 = 2500M, 11 = 10G.
- i_flow_ctrl_select  in  REG_DATA_WIDTH  [1:0] selects the fraction: 0 = 100%, 1 = 50%, 2 = 25%, 3 = 12.5%.
- i_cnt_clr  in  1  synchronous clear of all statistics counters.
- i_flow_data  in  PORT_MNG_DATA_WIDTH  upstream data.
- i_flow_data_keep  in  PORT_MNG_DATA_WIDTH/8  byte enables.
- i_flow_valid  in  1  upstream valid.
- o_flow_ready  out  1  upstream ready.
- i_flow_last  in  1  last beat of frame.
- o_flow_data  out  PORT_MNG_DATA_WIDTH  downstream data.
- o_flow_data_keep  out  PORT_MNG_DATA_WIDTH/8  downstream byte enables.
- o_flow_valid  out  1  downstream valid.
- i_flow_ready  in  1  downstream ready.
- o_flow_last  out  1  downstream last.
- o_send_package  out  32  frames sent (count of last-beat handshakes).
- o_send_byte  out  32  bytes sent.
- o_stall_cycle  out  32  cycles a frame was pending but blocked by credit.
- o_credit  out  CREDIT_WIDTH  current signed credit.

Behaviour:
- Reset: state IDLE, credit 0, tick counter 0, all counters 0, o_flow_valid/o_flow_ready/o_flow_last 0, data/keep 0.
- Tick: a counter runs 0..TICK_CYCLES-1; the tick pulses for one cycle at wrap.
- Refill per tick, in bytes = base >> i_flow_ctrl_select[1:0], with base 100/1000/2500/10000 for rate 00/01/10/11. Rate and select are sampled at the tick only.
- Credit update: credit_next = min(credit + refill − beat_bytes, CREDIT_MAX). Saturate the bottom at −2^(CREDIT_WIDTH−1).
  - refill is 0 if no tick this cycle.
  - beat_bytes = popcount(i_flow_data_keep) on a downstream handshake (o_flow_valid && i_flow_ready), else 0.
  - A tick and a deduction in the same cycle both apply.
- FSM IDLE:
  - o_flow_valid = 0, o_flow_ready = 0.
  - If i_flow_valid && credit > 0, go to XFER next cycle. This costs a 1-cycle bubble per frame.
  - If i_flow_valid && credit <= 0, increment the stall counter.
- FSM XFER (combinational pass-through, 0 latency):
  - o_flow_data/keep/last = inputs.
  - o_flow_valid = i_flow_valid.
  - o_flow_ready = i_flow_ready.
  - A handshake with i_flow_last returns the FSM to IDLE and increments o_send_package.
  - Credit may go negative mid-frame; frames are never cut.
- Deficit rule: the next frame starts only once credit > 0. Long-term throughput equals the configured rate.
- Rate or select change mid-frame: the current frame completes; the new refill applies from the next tick.
- Backpressure in XFER (i_flow_ready = 0): no deduction, no stall count, and data is held upstream by the deasserted ready.
- Counters: 32-bit, wrap to 0. i_cnt_clr zeroes them next cycle and takes priority over a same-cycle increment.
- Reset asserted mid-frame: the frame is abandoned and outputs drop immediately (async). After release the shaper waits in IDLE. Upstream must restart at a frame boundary.

Optional Feature:
- TX_SHAPER_STATS_EN defined: o_send_byte and o_stall_cycle counters are implemented as described.
- Undefined: both outputs are tied to 0 and their registers are removed. o_send_package and o_credit are unaffected.

Test Plan:
- Reset release, rate 01, select 0, one 64-byte frame presented at cycle 0:
  - o_flow_valid is first high at cycle TICK_CYCLES+1.
  - Credit goes 1000 → 936.
  - o_send_package = 1 and o_stall_cycle = 800.
- Rate 01, back-to-back 1500-byte frames (93 full beats + last keep 0x0FFF):
  - Credit goes 1000 → −500.
  - The second frame waits one tick (credit 500) then starts.
  - o_send_byte = 3000 after two frames.
- Rate 00, select 0, continuous 64-byte frames for 64000 cycles (80 ticks):
  - o_send_package = 125 ±1.
  - With select 2, the same run gives 31 ±1.
- Rate 11, no traffic for 20 ticks:
  - o_credit saturates at 16384, not 200000.
  - A tick coinciding with a 16-byte beat gives net +9984 (capped).
- i_flow_ready held low for 50 cycles mid-frame:
  - Credit is unchanged.
  - o_stall_cycle is unchanged.
  - No data is lost and the frame resumes on release.
- i_cnt_clr pulsed on the same cycle as a last-beat handshake:
  - All counters read 0 next cycle.
  - Without TX_SHAPER_STATS_EN, o_send_byte and o_stall_cycle stay 0 throughout.
